// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the fetch PC generator.
//   pc_state_e  - FSM state encoding (BOOT, RUN, PEND)
//   redir_sel_e - redirect source, numerically ordered by priority
//   DEF_*_VEC   - default reset and exception entry PCs
package pc_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } pc_state_e;

  // Higher value wins when several redirect requests arrive together.
  typedef enum logic [2:0] {
    SEL_SEQ    = 3'd0,
    SEL_BRANCH = 3'd1,
    SEL_JUMP   = 3'd2,
    SEL_ERET   = 3'd3,
    SEL_EXC    = 3'd4
  } redir_sel_e;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_0020;

endpackage

// File: rtl/pc_redirect_sel.sv
// pc_redirect_sel: combinational priority select of the fetch redirect.
//   branch_i/branch_target, jump_i/jump_target, exc_i, eret_i : requests
//   epc                                                       : saved exception PC
//   redirect : any request present
//   target   : PC of the winning request
//   is_exc   : the winning request is an exception
module pc_redirect_sel
  import pc_pkg::*;
#(
  parameter int unsigned       ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] EXC_VEC = ADDR_W'(DEF_EXC_VEC)
) (
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump_i,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              exc_i,
  input  logic              eret_i,
  input  logic [ADDR_W-1:0] epc,
  output logic              redirect,
  output logic [ADDR_W-1:0] target,
  output logic              is_exc
);

  redir_sel_e sel;

  always_comb begin
    sel = SEL_SEQ;
    if (exc_i)         sel = SEL_EXC;
    else if (eret_i)   sel = SEL_ERET;
    else if (jump_i)   sel = SEL_JUMP;
    else if (branch_i) sel = SEL_BRANCH;
  end

  always_comb begin
    target = '0;
    case (sel)
      SEL_EXC:    target = EXC_VEC;
      SEL_ERET:   target = epc;
      SEL_JUMP:   target = jump_target;
      SEL_BRANCH: target = branch_target;
      default:    target = '0;
    endcase
  end

  assign redirect = (sel != SEL_SEQ);
  assign is_exc   = (sel == SEL_EXC);

endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program counter generator.
//   clk, rst_n        : clock, asynchronous active-low reset
//   fetch_ready       : instruction memory accepts pc_o this cycle
//   pc_o, pc_valid    : fetch request
//   pc_plus           : pc_o + INC (combinational)
//   branch_i/_target, jump_i/_target, exc_i, eret_i : redirect requests
//   epc_o             : saved exception PC
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_BOOT | just out of reset, no fetch request, redirects ignored
// ST_RUN  | issuing fetches, sequential or redirected on acceptance
// ST_PEND | redirect captured during a stall, waiting for fetch_ready
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] INC       = ADDR_W'(1),
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
  parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(DEF_EXC_VEC)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_ready,
  output logic [ADDR_W-1:0] pc_o,
  output logic              pc_valid,
  output logic [ADDR_W-1:0] pc_plus,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump_i,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              exc_i,
  input  logic              eret_i,
  output logic [ADDR_W-1:0] epc_o
);

  pc_state_e         state, state_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] pend_target, pend_target_nxt;
  logic              pend_exc, pend_exc_nxt;
  logic              redirect;
  logic [ADDR_W-1:0] target;
  logic              is_exc;
  logic              take_new;

  pc_redirect_sel #(
    .ADDR_W  (ADDR_W),
    .EXC_VEC (EXC_VEC)
  ) u_sel (
    .branch_i      (branch_i),
    .branch_target (branch_target),
    .jump_i        (jump_i),
    .jump_target   (jump_target),
    .exc_i         (exc_i),
    .eret_i        (eret_i),
    .epc           (epc_o),
    .redirect      (redirect),
    .target        (target),
    .is_exc        (is_exc)
  );

  assign pc_plus  = pc_o + INC;
  assign pc_valid = (state != ST_BOOT);

  // A pending exception may only be displaced by another exception.
  assign take_new = redirect && (!pend_exc || is_exc);

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc_o;
    pend_target_nxt = pend_target;
    pend_exc_nxt    = pend_exc;
    case (state)
      ST_BOOT: state_nxt = ST_RUN;
      ST_RUN: begin
        if (fetch_ready) begin
          pc_nxt = redirect ? target : pc_plus;
        end else if (redirect) begin
          pend_target_nxt = target;
          pend_exc_nxt    = is_exc;
          state_nxt       = ST_PEND;
        end
      end
      ST_PEND: begin
        if (take_new) begin
          pend_target_nxt = target;
          pend_exc_nxt    = is_exc;
        end
        if (fetch_ready) begin
          pc_nxt    = take_new ? target : pend_target;
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_BOOT;
      pc_o        <= RESET_VEC;
      pend_target <= '0;
      pend_exc    <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc_o        <= pc_nxt;
      pend_target <= pend_target_nxt;
      pend_exc    <= pend_exc_nxt;
    end
  end

  // EPC records the PC presented in the cycle the exception is taken,
  // whether or not fetch is stalled at that moment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      epc_o <= '0;
    end else if (exc_i && (state != ST_BOOT)) begin
      epc_o <= pc_o;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_ready = 1'b0;
  logic        branch_i = 1'b0, jump_i = 1'b0, exc_i = 1'b0, eret_i = 1'b0;
  logic [31:0] branch_target = '0, jump_target = '0;
  logic [31:0] pc_o, pc_plus, epc_o;
  logic        pc_valid;

  logic        w_ready = 1'b0;
  logic        w_zero = 1'b0;
  logic [7:0]  w_zero_t = '0;
  logic [7:0]  w_pc, w_plus, w_epc;
  logic        w_valid;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk(clk), .rst_n(rst_n), .fetch_ready(fetch_ready),
    .pc_o(pc_o), .pc_valid(pc_valid), .pc_plus(pc_plus),
    .branch_i(branch_i), .branch_target(branch_target),
    .jump_i(jump_i), .jump_target(jump_target),
    .exc_i(exc_i), .eret_i(eret_i), .epc_o(epc_o)
  );

  pc_gen #(.ADDR_W(8), .INC(8'd4), .RESET_VEC(8'hF8), .EXC_VEC(8'h20)) dut_w (
    .clk(clk), .rst_n(rst_n), .fetch_ready(w_ready),
    .pc_o(w_pc), .pc_valid(w_valid), .pc_plus(w_plus),
    .branch_i(w_zero), .branch_target(w_zero_t),
    .jump_i(w_zero), .jump_target(w_zero_t),
    .exc_i(w_zero), .eret_i(w_zero), .epc_o(w_epc)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Behavioural reference: a fetch PC, a saved EPC and at most one
  // outstanding redirect that is committed when memory accepts.
  bit          m_booted;
  bit [31:0]   m_pc, m_epc;
  bit          m_has_pend, m_pend_exc;
  bit [31:0]   m_pend_pc;

  task automatic model_reset();
    m_booted = 0; m_pc = 0; m_epc = 0;
    m_has_pend = 0; m_pend_exc = 0; m_pend_pc = 0;
  endtask

  task automatic model_step();
    bit        req;
    bit        req_exc;
    bit [31:0] req_pc;
    if (!m_booted) begin
      m_booted = 1;
      return;
    end
    req = 1; req_exc = 0; req_pc = 0;
    if (exc_i)         begin req_pc = 32'h20; req_exc = 1; end
    else if (eret_i)   req_pc = m_epc;
    else if (jump_i)   req_pc = jump_target;
    else if (branch_i) req_pc = branch_target;
    else               req = 0;
    if (exc_i) m_epc = m_pc;
    if (!m_has_pend && req && !fetch_ready) begin
      m_has_pend = 1; m_pend_pc = req_pc; m_pend_exc = req_exc;
    end else if (m_has_pend) begin
      if (req && (!m_pend_exc || req_exc)) begin
        m_pend_pc = req_pc; m_pend_exc = req_exc;
      end
      if (fetch_ready) begin
        m_pc = m_pend_pc; m_has_pend = 0;
      end
    end else if (fetch_ready) begin
      m_pc = req ? req_pc : m_pc + 32'd1;
    end
  endtask

  task automatic drive_cycle();
    if (rst_n) model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic rdy, input logic br, input logic [31:0] bt,
                        input logic jp, input logic [31:0] jt, input logic ex, input logic er);
    fetch_ready = rdy; branch_i = br; branch_target = bt;
    jump_i = jp; jump_target = jt; exc_i = ex; eret_i = er;
  endtask

  typedef struct {
    logic        rdy, br;
    logic [31:0] bt;
    logic        jp;
    logic [31:0] jt;
    logic        ex, er;
    logic [31:0] pc, epc;
  } vec_t;

  function automatic vec_t mk(logic rdy, logic br, logic [31:0] bt, logic jp, logic [31:0] jt,
                              logic ex, logic er, logic [31:0] pc, logic [31:0] epc);
    vec_t v;
    v.rdy = rdy; v.br = br; v.bt = bt; v.jp = jp; v.jt = jt;
    v.ex = ex; v.er = er; v.pc = pc; v.epc = epc;
    return v;
  endfunction

  vec_t tbl [28];

  initial begin
    string nm;
    tbl[0]  = mk(1,0,0,0,0,0,0, 32'h00, 32'h00);
    tbl[1]  = mk(1,0,0,0,0,0,0, 32'h01, 32'h00);
    tbl[2]  = mk(1,0,0,0,0,0,0, 32'h02, 32'h00);
    tbl[3]  = mk(1,0,0,0,0,0,0, 32'h03, 32'h00);
    tbl[4]  = mk(1,0,0,0,0,0,0, 32'h04, 32'h00);
    tbl[5]  = mk(1,0,0,0,0,0,0, 32'h05, 32'h00);
    tbl[6]  = mk(0,1,32'h40,0,0,0,0, 32'h05, 32'h00);
    tbl[7]  = mk(0,0,0,0,0,0,0, 32'h05, 32'h00);
    tbl[8]  = mk(0,0,0,0,0,0,0, 32'h05, 32'h00);
    tbl[9]  = mk(1,0,0,0,0,0,0, 32'h40, 32'h00);
    tbl[10] = mk(1,0,0,0,0,0,0, 32'h41, 32'h00);
    tbl[11] = mk(0,0,0,0,0,1,0, 32'h41, 32'h41);
    tbl[12] = mk(1,0,0,1,32'h80,0,0, 32'h20, 32'h41);
    tbl[13] = mk(1,0,0,0,0,0,0, 32'h21, 32'h41);
    tbl[14] = mk(1,0,0,1,32'h12,0,0, 32'h12, 32'h41);
    tbl[15] = mk(1,0,0,0,0,1,0, 32'h20, 32'h12);
    tbl[16] = mk(1,0,0,0,0,0,0, 32'h21, 32'h12);
    tbl[17] = mk(1,0,0,0,0,0,1, 32'h12, 32'h12);
    tbl[18] = mk(1,0,0,0,0,0,0, 32'h13, 32'h12);
    tbl[19] = mk(1,0,0,0,0,1,1, 32'h20, 32'h13);
    tbl[20] = mk(1,1,32'h55,1,32'h66,0,0, 32'h66, 32'h13);
    tbl[21] = mk(1,0,0,1,32'h77,0,1, 32'h13, 32'h13);
    tbl[22] = mk(0,1,32'h30,0,0,0,0, 32'h13, 32'h13);
    tbl[23] = mk(0,0,0,1,32'h90,0,0, 32'h13, 32'h13);
    tbl[24] = mk(1,0,0,0,0,0,0, 32'h90, 32'h13);
    tbl[25] = mk(0,0,0,0,0,1,0, 32'h90, 32'h90);
    tbl[26] = mk(1,0,0,0,0,0,1, 32'h20, 32'h90);
    tbl[27] = mk(1,0,0,0,0,0,0, 32'h21, 32'h90);

    // Reset state
    model_reset();
    #12;
    check("rst_pc", pc_o, 32'h0);
    check("rst_valid", {31'b0, pc_valid}, 32'h0);
    check("rst_epc", epc_o, 32'h0);
    check("rst_plus", pc_plus, 32'h1);
    check("rst_w_pc", {24'b0, w_pc}, 32'hF8);
    check("rst_w_valid", {31'b0, w_valid}, 32'h0);

    // Wrap-around on the 8-bit, INC=4 instance
    @(posedge clk); #1;
    rst_n = 1'b1;
    w_ready = 1'b1;
    check("boot_valid", {31'b0, pc_valid}, 32'h0);
    begin
      logic [7:0] wexp [4];
      wexp[0] = 8'hF8; wexp[1] = 8'hFC; wexp[2] = 8'h00; wexp[3] = 8'h04;
      for (int i = 0; i < 4; i++) begin
        drive_cycle();
        check("wrap_pc", {24'b0, w_pc}, {24'b0, wexp[i]});
        check("wrap_valid", {31'b0, w_valid}, 32'h1);
        check("wrap_plus", {24'b0, w_plus}, {24'b0, wexp[i] + 8'd4});
      end
    end
    w_ready = 1'b0;

    // Fresh reset, then the directed table
    rst_n = 1'b0;
    #2;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("boot_valid2", {31'b0, pc_valid}, 32'h0);
    for (int i = 0; i < 28; i++) begin
      set_in(tbl[i].rdy, tbl[i].br, tbl[i].bt, tbl[i].jp, tbl[i].jt, tbl[i].ex, tbl[i].er);
      drive_cycle();
      nm = $sformatf("tbl%0d", i);
      check({nm, "_pc"}, pc_o, tbl[i].pc);
      check({nm, "_valid"}, {31'b0, pc_valid}, 32'h1);
      check({nm, "_plus"}, pc_plus, tbl[i].pc + 32'd1);
      check({nm, "_epc"}, epc_o, tbl[i].epc);
    end

    // Randomised run against the reference model
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 9) < 6,
             $urandom_range(0, 9) < 2, $urandom,
             $urandom_range(0, 9) < 1, $urandom,
             $urandom_range(0, 19) < 1,
             $urandom_range(0, 14) < 1);
      drive_cycle();
      check("rnd_pc", pc_o, m_pc);
      check("rnd_valid", {31'b0, pc_valid}, 32'h1);
      check("rnd_plus", pc_plus, m_pc + 32'd1);
      check("rnd_epc", epc_o, m_epc);
    end

    // Async reset while a redirect is pending
    set_in(1, 0, 0, 1, 32'h0000_1234, 0, 0);
    drive_cycle();
    set_in(0, 0, 0, 0, 0, 1, 0);
    drive_cycle();
    check("pre_rst_epc", epc_o, 32'h0000_1234);
    set_in(0, 1, 32'h44, 0, 0, 0, 0);
    drive_cycle();
    check("pend_hold", pc_o, 32'h0000_1234);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_pc", pc_o, 32'h0);
    check("arst_valid", {31'b0, pc_valid}, 32'h0);
    check("arst_epc", epc_o, 32'h0);
    set_in(1, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    check("arst_hold_pc", pc_o, 32'h0);
    rst_n = 1'b1;
    check("arst_boot_valid", {31'b0, pc_valid}, 32'h0);
    drive_cycle();
    check("arst_first_pc", pc_o, 32'h0);
    check("arst_first_valid", {31'b0, pc_valid}, 32'h1);
    drive_cycle();
    check("arst_second_pc", pc_o, 32'h1);
    drive_cycle();
    check("arst_third_pc", pc_o, 32'h2);
    check("arst_epc_after", epc_o, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
